temp_sample_ctrl: RTL and testbench

- Periodic measurement controller for the temperature-calculation datapath.
- Requests ADC conversions on a programmable period or on demand, and snapshots the ADC sample with the base/reference operands.
- Computes tempc on one shared shift-add multiplier: ref², then ×magnitude, then >>5 and signed add/sub against base.
- Presents each result on a valid/ready output; flags ADC timeouts and sample overruns.

---
 rtl/temp_sample_ctrl.sv | 166 ++++++++++++++++
 tb/tb_temp_sample_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_ctrl.sv
// Periodic temperature measurement controller: requests ADC samples, computes
// tempc = base +/- ((ref*ref*mag) >> 5) on one shared shift-add multiplier.
module temp_sample_ctrl #(
   parameter int unsigned SAMPLE_PERIOD = 1000,
   parameter int unsigned ADC_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        start,
   input  logic [31:0] tc_base,
   input  logic [7:0]  tc_ref,
   output logic        adc_req,
   input  logic        adc_ack,
   input  logic [15:0] adc_data,
   output logic [31:0] tempc,
   output logic        tempc_valid,
   input  logic        tempc_ready,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_overrun,
   input  logic        clear_err
);

   localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
   localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ADC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_REQ, S_MUL1, S_MUL2, S_ACC, S_OUT
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0] per_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0]    bit_cnt;
   logic          smp_sign;
   logic [14:0]   smp_mag;
   logic [31:0]   smp_base;
   logic [30:0]   acc;
   logic [30:0]   mcand;
   logic [15:0]   mplier;
   logic [30:0]   acc_sum;
   logic          per_hit;
   logic          to_hit;
   logic          hshake;

   assign per_hit = (per_cnt == PERIOD_LAST);
   assign to_hit  = (to_cnt == TIMEOUT_LAST);
   assign hshake  = tempc_valid && tempc_ready;
   assign acc_sum = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      adc_req   = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (enable) state_nxt = S_ARM;
         end
         S_ARM: begin
            busy = 1'b0;
            if (!enable)               state_nxt = S_IDLE;
            else if (per_hit || start) state_nxt = S_REQ;
         end
         S_REQ: begin
            adc_req = 1'b1;
            if (adc_ack)      state_nxt = S_MUL1;
            else if (to_hit)  state_nxt = S_ARM;
            else if (!enable) state_nxt = S_IDLE;
         end
         S_MUL1: if (bit_cnt == 4'd7)  state_nxt = S_MUL2;
         S_MUL2: if (bit_cnt == 4'd15) state_nxt = S_ACC;
         S_ACC:  state_nxt = S_OUT;
         S_OUT:  if (hshake) state_nxt = enable ? S_ARM : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Period counter free-runs outside IDLE; expiries outside ARM start no request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt <= '0;
         to_cnt  <= '0;
      end else begin
         if (state == S_IDLE || state_nxt == S_IDLE)  per_cnt <= '0;
         else if (per_hit || (state == S_ARM && start)) per_cnt <= '0;
         else                                          per_cnt <= per_cnt + 1'b1;
         to_cnt <= (state == S_REQ) ? to_cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (state == S_REQ && !adc_ack && to_hit) err_timeout <= 1'b1;
         else if (clear_err)                        err_timeout <= 1'b0;
         if (state == S_OUT && per_hit)             err_overrun <= 1'b1;
         else if (clear_err)                        err_overrun <= 1'b0;
      end
   end

   // MUL1 squares ref into acc[15:0]; that square becomes MUL2's multiplicand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_sign    <= 1'b0;
         smp_mag     <= '0;
         smp_base    <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         bit_cnt     <= '0;
         tempc       <= '0;
         tempc_valid <= 1'b0;
      end else begin
         case (state)
            S_REQ: if (adc_ack) begin
               smp_sign <= adc_data[15];
               smp_mag  <= adc_data[14:0];
               smp_base <= tc_base;
               acc      <= '0;
               mcand    <= {23'd0, tc_ref};
               mplier   <= {8'd0, tc_ref};
               bit_cnt  <= '0;
            end
            S_MUL1: begin
               if (bit_cnt == 4'd7) begin
                  acc     <= '0;
                  mcand   <= {15'd0, acc_sum[15:0]};
                  mplier  <= {1'b0, smp_mag};
                  bit_cnt <= '0;
               end else begin
                  acc     <= acc_sum;
                  mcand   <= mcand << 1;
                  mplier  <= mplier >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_MUL2: begin
               acc     <= acc_sum;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               bit_cnt <= bit_cnt + 1'b1;
            end
            S_ACC: begin
               tempc       <= smp_sign ? smp_base - {6'd0, acc[30:5]}
                                       : smp_base + {6'd0, acc[30:5]};
               tempc_valid <= 1'b1;
            end
            S_OUT: if (hshake) tempc_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Randomized self-checking bench for temp_sample_ctrl against an arithmetic
// reference of the result formula and the cycle-count rules for timing.
module tb_temp_sample_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        start;
   logic [31:0] tc_base;
   logic [7:0]  tc_ref;
   logic        adc_req;
   logic        adc_ack;
   logic [15:0] adc_data;
   logic [31:0] tempc;
   logic        tempc_valid;
   logic        tempc_ready;
   logic        busy;
   logic        err_timeout;
   logic        err_overrun;
   logic        clear_err;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned cyc = 0;

   temp_sample_ctrl #(.SAMPLE_PERIOD(40), .ADC_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start),
      .tc_base(tc_base), .tc_ref(tc_ref), .adc_req(adc_req),
      .adc_ack(adc_ack), .adc_data(adc_data), .tempc(tempc),
      .tempc_valid(tempc_valid), .tempc_ready(tempc_ready), .busy(busy),
      .err_timeout(err_timeout), .err_overrun(err_overrun), .clear_err(clear_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_tempc(input logic [7:0] r, input logic [31:0] base,
                                             input logic [15:0] d);
      logic [63:0] prod;
      logic [31:0] q;
      prod = 64'(r) * 64'(r) * 64'(d[14:0]);
      q = 32'(prod >> 5);
      return d[15] ? base - q : base + q;
   endfunction

   task automatic scramble();
      tc_base  = $urandom;
      tc_ref   = 8'($urandom);
      adc_data = 16'($urandom);
   endtask

   task automatic go_arm();
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_conv(input string tag, input logic [7:0] r, input logic [31:0] b,
                           input logic [15:0] d, input int ack_dly, input int hold,
                           input bit drop_en);
      logic [31:0] exp;
      int k;
      int held_bad;
      exp = ref_tempc(r, b, d);
      go_arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_req"}, 32'(adc_req), 32'd1);
      repeat (ack_dly) begin
         scramble();
         @(negedge clk);
      end
      adc_ack = 1'b1; adc_data = d; tc_base = b; tc_ref = r;
      @(negedge clk);
      adc_ack = 1'b0;
      scramble();
      check({tag, "_req_low"}, 32'({adc_req, busy}), 32'b01);
      if (drop_en) enable = 1'b0;
      k = 0;
      while (tempc_valid !== 1'b1 && k < 40) begin
         @(negedge clk);
         scramble();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'd25);
      check({tag, "_tempc"}, tempc, exp);
      held_bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (tempc_valid !== 1'b1 || tempc !== exp) held_bad++;
      end
      check({tag, "_hold"}, 32'(held_bad), 32'd0);
      tempc_ready = 1'b1;
      @(negedge clk);
      tempc_ready = 1'b0;
      check({tag, "_released"}, 32'({tempc_valid, busy}), 32'b00);
      enable = 1'b1;
   endtask

   initial begin
      int n;
      int seen;
      int unsigned t_prev;
      int unsigned t_req;
      logic [7:0]  r;
      logic [31:0] b;
      logic [15:0] d;
      logic [31:0] saved;

      rst = 1'b1; enable = 1'b0; start = 1'b0; adc_ack = 1'b0;
      tempc_ready = 1'b0; clear_err = 1'b0;
      tc_base = '0; tc_ref = '0; adc_data = '0;
      t_prev = 0;
      repeat (2) @(negedge clk);
      check("rst_outputs", {26'd0, adc_req, tempc_valid, busy, err_timeout, err_overrun, 1'b0}, 32'd0);
      check("rst_tempc", tempc, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_conv("nominal", 8'd2, 32'd25, 16'h0010, 0, 10, 1'b0);
      run_conv("neg_wrap", 8'd1, 32'd0, 16'h8020, 1, 0, 1'b0);
      run_conv("neg", 8'd2, 32'd25, 16'h8010, 0, 2, 1'b0);
      run_conv("max_pos", 8'd255, 32'd0, 16'h7FFF, 2, 0, 1'b0);
      run_conv("max_neg", 8'd255, 32'h7FFFFFFF, 16'hFFFF, 0, 1, 1'b0);
      run_conv("ref_zero", 8'd0, 32'd5, 16'h7FFF, 1, 0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         run_conv("rand", 8'($urandom), $urandom, 16'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 8)),
                  ($urandom_range(0, 3) == 0));
      end

      // ADC timeout; clear_err held on the error edge must lose
      go_arm();
      clear_err = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (adc_req === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("timeout_req_cycles", 32'(n), 32'd4);
      check("timeout_flag", 32'({err_timeout, busy}), 32'b10);
      clear_err = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("timeout_back_in_arm", 32'(adc_req), 32'd1);
      enable = 1'b0;
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("timeout_cleared", 32'(err_timeout), 32'd0);

      // Periodic sampling, then overrun on the last result
      tempc_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (adc_req !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
         end
         check("per_req_seen", 32'(adc_req), 32'd1);
         t_req = cyc;
         if (i > 0) check("per_interval", t_req - t_prev, 32'd40);
         t_prev = t_req;
         @(negedge clk);
         r = 8'($urandom); b = $urandom; d = 16'($urandom);
         adc_ack = 1'b1; tc_ref = r; tc_base = b; adc_data = d;
         @(negedge clk);
         adc_ack = 1'b0;
         scramble();
         if (i == 3) tempc_ready = 1'b0;
         n = 0;
         while (tempc_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("per_tempc", tempc, ref_tempc(r, b, d));
      end
      saved = tempc;
      seen = 0;
      n = 0;
      while (err_overrun !== 1'b1 && n < 80) begin
         @(negedge clk);
         if (adc_req === 1'b1) seen++;
         n++;
      end
      check("overrun_time", cyc - t_req, 32'd40);
      check("overrun_pending", 32'({err_overrun, tempc_valid}), 32'b11);
      repeat (15) begin
         @(negedge clk);
         if (adc_req === 1'b1) seen++;
      end
      check("overrun_no_req", 32'(seen), 32'd0);
      check("overrun_held", tempc, saved);
      tempc_ready = 1'b1;
      @(negedge clk);
      tempc_ready = 1'b0;
      check("overrun_released", 32'(tempc_valid), 32'd0);
      n = 0;
      while (adc_req !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("overrun_next_req", cyc - t_req, 32'd80);
      enable = 1'b0;
      @(negedge clk);
      check("abort_req_low", 32'(adc_req), 32'd0);

      // Enable dropped while requesting: late ack is ignored
      saved = tempc;
      go_arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("drop_en_req", 32'(adc_req), 32'd1);
      enable = 1'b0;
      @(negedge clk);
      check("drop_en_idle", 32'({adc_req, busy}), 32'b00);
      adc_ack = 1'b1;
      scramble();
      @(negedge clk);
      adc_ack = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (tempc_valid !== 1'b0 || adc_req !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("late_ack_ignored", 32'(seen), 32'd0);
      check("late_ack_tempc", tempc, saved);

      // Asynchronous reset in the middle of the second multiply
      go_arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      adc_ack = 1'b1;
      scramble();
      @(negedge clk);
      adc_ack = 1'b0;
      enable = 1'b0;
      repeat (12) @(negedge clk);
      check("pre_rst_state", 32'({busy, err_overrun}), 32'b11);
      #1 rst = 1'b1;
      #1;
      check("async_rst_flags", {27'd0, adc_req, tempc_valid, busy, err_timeout, err_overrun}, 32'd0);
      check("async_rst_tempc", tempc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (tempc_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
